// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
package hex_display_pkg;

    // Active-low segment vector, bit order gfedcba (bit 6 = g).
    typedef logic [6:0] seg_t;

    // All segments off.
    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low glyphs for hex digits 0..F.
    localparam seg_t HEX_SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_display_mux_seg7_lut.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module seg7_lut
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = HEX_SEG_LUT[nibble_i];

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed driver for an N-digit common-anode hex display.
// One decoder is shared across all digits; the scan counter selects which
// shadowed nibble reaches it, and the result is registered onto the pins.
module hex_display_mux
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    blank_lz,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodes
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W  = $clog2(REFRESH_DIV);
    localparam int WORD_W = 4 * NUM_DIGITS;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tick;

    // Shadow copy of the displayed word
    logic [WORD_W-1:0]     shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;

    // Digit selection and decode
    logic [3:0]            nibble;
    logic                  dp_sel;
    logic [IDX_W-1:0]      msd;
    logic                  blank_digit;
    seg_t                  lut_seg;

    // Output register
    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    // Prescaler and digit index advance; both freeze while disabled.
    always_comb begin
        pre_d = pre_q;
        idx_d = idx_q;
        tick  = enable && (pre_q == PRE_LAST);
        if (enable) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
        if (tick) begin
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Shadow capture on load, regardless of enable.
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (load) begin
            shadow_data_d = data_in;
            shadow_dp_d   = dp_in;
        end
    end

    // Mux the current digit and find the most significant nonzero nibble;
    // later (higher) nonzero nibbles overwrite msd so the highest one wins.
    always_comb begin
        nibble = 4'h0;
        dp_sel = 1'b0;
        msd    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nibble = shadow_data_q[4*k +: 4];
                dp_sel = shadow_dp_q[k];
            end
            if (shadow_data_q[4*k +: 4] != 4'h0) begin
                msd = IDX_W'(k);
            end
        end
        blank_digit = blank_lz && (idx_q > msd);
    end

    seg7_lut u_seg7_lut (
        .nibble_i (nibble),
        .seg_o    (lut_seg)
    );

    // Next output values: lit digit when enabled, fully dark otherwise.
    // The decimal point ignores leading-zero blanking.
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        if (enable) begin
            seg_d = blank_digit ? SEG_BLANK : lut_seg;
            dp_d  = ~dp_sel;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                an_d[k] = (idx_q != IDX_W'(k));
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q         <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            an_q          <= '1;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign segments = seg_q;
    assign dp       = dp_q;
    assign anodes   = an_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Scoreboard bench for hex_display_mux with NUM_DIGITS=4, REFRESH_DIV=4.
// The reference tracks only the number of enabled edges since reset and the
// shadowed word; the lit digit follows arithmetically from that count.
module tb_hex_display_mux;

    localparam int ND = 4;
    localparam int RD = 4;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anodes;

    hex_display_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .load     (load),
        .enable   (enable),
        .blank_lz (blank_lz),
        .segments (segments),
        .dp       (dp),
        .anodes   (anodes)
    );

    always #5 clk = ~clk;

    logic [6:0] ref_lut [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    logic [15:0] m_shadow = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    int          m_e = 0;

    // Drive one edge worth of inputs and queue the output that edge must produce.
    task automatic step(input logic r, input logic l, input logic e, input logic b,
                        input logic [15:0] d, input logic [3:0] p);
        exp_t       x;
        int         dig;
        int         msd;
        logic [3:0] one_hot;
        @(negedge clk);
        rst = r; load = l; enable = e; blank_lz = b; data_in = d; dp_in = p;
        x = {7'h7F, 1'b1, 4'hF};
        if (r) begin
            m_shadow = 16'h0;
            m_dp     = 4'h0;
            m_e      = 0;
        end else begin
            if (e) begin
                dig = (m_e / RD) % ND;
                msd = 0;
                for (int k = 0; k < ND; k++) begin
                    if (m_shadow[4*k +: 4] != 4'h0) msd = k;
                end
                one_hot = 4'b0001 << dig;
                x.seg = (b && dig > msd) ? 7'h7F : ref_lut[m_shadow[4*dig +: 4]];
                x.dp  = ~m_dp[dig];
                x.an  = ~one_hot;
                m_e++;
            end
            if (l) begin
                m_shadow = d;
                m_dp     = p;
            end
        end
        sb.push_back(x);
    endtask

    task automatic idle(input int n, input logic e, input logic b);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, e, b, 16'h0, 4'h0);
    endtask

    // Run enabled until the given digit is about to see the given prescaler count.
    task automatic run_until(input int digit, input int rem, input logic b);
        int n;
        n = 0;
        while (!(((m_e / RD) % ND) == digit && (m_e % RD) == rem) && n < 100) begin
            step(1'b0, 1'b0, 1'b1, b, 16'h0, 4'h0);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL run_until timeout digit=%0d rem=%0d got e=%0d required position", digit, rem, m_e);
        end
    endtask

    // Monitor: every edge produces an output; compare it with the queued expectation.
    initial begin
        exp_t want;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                want = sb.pop_front();
                got  = {segments, dp, anodes};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL out cyc=%0d got seg=%h dp=%b an=%h required seg=%h dp=%b an=%h",
                             cyc, got.seg, got.dp, got.an, want.seg, want.dp, want.an);
                end
            end
        end
    end

    initial begin
        logic [15:0] d;
        logic        r, l, e, b;
        // Reset, then free-running scan of an all-zero word.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        idle(20, 1'b1, 1'b0);
        // Full hex word, no blanking.
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h1A3F, 4'h0);
        idle(20, 1'b1, 1'b0);
        // Leading-zero blanking.
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h003C, 4'h0);
        idle(20, 1'b1, 1'b1);
        // All zero with a dp on a blanked digit.
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'b0100);
        idle(20, 1'b1, 1'b1);
        // Enable dropped mid-digit 2, then resumed.
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h1A3F, 4'b1010);
        run_until(2, 1, 1'b0);
        idle(10, 1'b0, 1'b0);
        idle(12, 1'b1, 1'b0);
        // Load coinciding with a digit change.
        run_until(1, 3, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h8E75, 4'b0001);
        idle(8, 1'b1, 1'b0);
        // Reset during digit 3 with a simultaneous load.
        run_until(3, 1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF);
        idle(16, 1'b1, 1'b1);
        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 7) != 0);
            b = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            for (int k = 0; k < ND; k++) begin
                if ($urandom_range(0, 1) == 1) d[4*k +: 4] = 4'h0;
            end
            step(r, l, e, b, d, 4'($urandom));
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
